// File: rtl/led_shift_driver.sv
// Serializes a WIDTH-bit LED pattern onto a 74HC595-style chain (SER/SRCLK/RCLK).
// Updates arriving mid-frame are held in a one-deep "latest wins" buffer and start the next frame.
module led_shift_driver #(
   parameter int WIDTH     = 8,
   parameter int CLK_DIV   = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             BUSY,
   output logic             SER,
   output logic             SRCLK,
   output logic             RCLK,
   output logic             DONE
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic               pend_vld_q, pend_vld_d;
   logic               ser_q, ser_d;
   logic               srclk_q, srclk_d;
   logic               rclk_q, rclk_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   load_val;
   logic [WIDTH-1:0]   shift_nxt;
   logic               div_last;

   function automatic logic first_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ser_d      = ser_q;
      srclk_d    = srclk_q;
      rclk_d     = rclk_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_last   = (div_q == DIV_LAST);
      load_val   = DIN_VALID ? DIN : pend_q;
      shift_nxt  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

      // A strobe during a frame only updates the buffer; the newest value wins.
      if (DIN_VALID && state_q != S_IDLE) begin
         pend_d     = DIN;
         pend_vld_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (DIN_VALID || pend_vld_q) begin
               shift_d    = load_val;
               ser_d      = first_bit(load_val);
               pend_vld_d = 1'b0;
               srclk_d    = 1'b0;
               busy_d     = 1'b1;
               div_d      = '0;
               bit_d      = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            div_d = div_q + 1'b1;
            if (div_last) begin
               div_d = '0;
               if (!srclk_q) begin
                  srclk_d = 1'b1;
               end else if (bit_q == BIT_LAST) begin
                  srclk_d = 1'b0;
                  ser_d   = 1'b0;
                  rclk_d  = 1'b1;
                  state_d = S_LATCH;
               end else begin
                  // SER only moves on the falling SRCLK edge, giving a full phase of setup and hold.
                  srclk_d = 1'b0;
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_nxt;
                  ser_d   = first_bit(shift_nxt);
               end
            end
         end
         S_LATCH: begin
            div_d = div_q + 1'b1;
            if (div_last) begin
               div_d   = '0;
               rclk_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ser_q      <= 1'b0;
         srclk_q    <= 1'b0;
         rclk_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ser_q      <= ser_d;
         srclk_q    <= srclk_d;
         rclk_q     <= rclk_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign BUSY  = busy_q;
   assign SER   = ser_q;
   assign SRCLK = srclk_q;
   assign RCLK  = rclk_q;
   assign DONE  = done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: three configurations (8/4 MSB-first, 8/4 LSB-first, 4/1 MSB-first).
// Stimulus queues expected frames; a negedge monitor rebuilds each frame from the pins and compares.
module tb_led_shift_driver;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST;
   logic [7:0] din_m, din_l;
   logic [3:0] din_s;
   logic       vld_m, vld_l, vld_s;
   logic       busy_m, ser_m, srclk_m, rclk_m, done_m;
   logic       busy_l, ser_l, srclk_l, rclk_l, done_l;
   logic       busy_s, ser_s, srclk_s, rclk_s, done_s;

   led_shift_driver #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_dut (
      .CLK(CLK), .RST(RST), .DIN(din_m), .DIN_VALID(vld_m), .BUSY(busy_m),
      .SER(ser_m), .SRCLK(srclk_m), .RCLK(rclk_m), .DONE(done_m));

   led_shift_driver #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_lsb (
      .CLK(CLK), .RST(RST), .DIN(din_l), .DIN_VALID(vld_l), .BUSY(busy_l),
      .SER(ser_l), .SRCLK(srclk_l), .RCLK(rclk_l), .DONE(done_l));

   led_shift_driver #(.WIDTH(4), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_small (
      .CLK(CLK), .RST(RST), .DIN(din_s), .DIN_VALID(vld_s), .BUSY(busy_s),
      .SER(ser_s), .SRCLK(srclk_s), .RCLK(rclk_s), .DONE(done_s));

   wire [2:0] busy_v  = {busy_s, busy_l, busy_m};
   wire [2:0] ser_v   = {ser_s, ser_l, ser_m};
   wire [2:0] srclk_v = {srclk_s, srclk_l, srclk_m};
   wire [2:0] rclk_v  = {rclk_s, rclk_l, rclk_m};
   wire [2:0] done_v  = {done_s, done_l, done_m};

   // Hand-derived per-instance frame geometry: DONE offset, RCLK offset/length, bit count.
   localparam int LEN  [3] = '{68, 68, 9};
   localparam int ROFF [3] = '{64, 64, 8};
   localparam int RLEN [3] = '{4, 4, 1};
   localparam int NBIT [3] = '{8, 8, 4};
   localparam int NDONE[3] = '{5, 1, 1};

   typedef struct {
      logic [7:0] word;
      int         gap;
      bit         abort;
   } frame_t;

   frame_t exp_q[3][$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string nm, input int inst, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s inst=%0d got=%0d expected=%0d (t=%0t)", nm, inst, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Monitor
   int         in_frame[3], start_c[3], busy_cnt[3], rclk_cnt[3], rclk_first[3];
   int         nbits[3], last_done[3], done_tot[3];
   logic [7:0] rx[3];
   logic       prev_busy[3], prev_srclk[3];
   bit         chk_zero = 1'b0;

   initial begin
      frame_t f;
      for (int i = 0; i < 3; i++) begin
         in_frame[i] = 0; busy_cnt[i] = 0; rclk_cnt[i] = 0; rclk_first[i] = -1;
         nbits[i] = 0; last_done[i] = -1000; done_tot[i] = 0; rx[i] = '0;
         prev_busy[i] = 1'b0; prev_srclk[i] = 1'b0; start_c[i] = 0;
      end
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 3; i++) begin
            if (chk_zero) begin
               check("reset_outputs", i,
                     int'({busy_v[i], ser_v[i], srclk_v[i], rclk_v[i], done_v[i]}), 0);
               if (in_frame[i] != 0 && exp_q[i].size() != 0) begin
                  f = exp_q[i].pop_front();
                  check("frame_expected_abort", i, int'(f.abort), 1);
                  check("rclk_before_reset", i, rclk_cnt[i], 0);
               end
               in_frame[i] = 0;
            end else begin
               if (busy_v[i] && !prev_busy[i]) begin
                  check("frame_queued", i, int'(exp_q[i].size() != 0), 1);
                  if (exp_q[i].size() != 0) begin
                     in_frame[i] = 1; start_c[i] = cyc; busy_cnt[i] = 0; rclk_cnt[i] = 0;
                     rclk_first[i] = -1; nbits[i] = 0; rx[i] = '0;
                     if (exp_q[i][0].gap >= 0)
                        check("idle_gap", i, cyc - last_done[i], exp_q[i][0].gap);
                  end
               end
               if (in_frame[i] != 0) begin
                  if (busy_v[i]) busy_cnt[i]++;
                  if (srclk_v[i] && !prev_srclk[i]) begin
                     rx[i] = {rx[i][6:0], ser_v[i]};
                     nbits[i]++;
                  end
                  if (rclk_v[i]) begin
                     if (rclk_first[i] < 0) rclk_first[i] = cyc - start_c[i];
                     rclk_cnt[i]++;
                  end
               end else begin
                  check("idle_rclk", i, int'(rclk_v[i]), 0);
                  check("idle_srclk", i, int'(srclk_v[i]), 0);
               end
               if (done_v[i]) begin
                  done_tot[i]++;
                  check("done_in_frame", i, in_frame[i], 1);
                  if (in_frame[i] != 0 && exp_q[i].size() != 0) begin
                     f = exp_q[i].pop_front();
                     check("frame_not_aborted", i, int'(f.abort), 0);
                     check("shifted_word", i, int'(rx[i]), int'(f.word));
                     check("bit_count", i, nbits[i], NBIT[i]);
                     check("busy_cycles", i, busy_cnt[i], LEN[i]);
                     check("done_offset", i, cyc - start_c[i], LEN[i]);
                     check("rclk_offset", i, rclk_first[i], ROFF[i]);
                     check("rclk_cycles", i, rclk_cnt[i], RLEN[i]);
                     check("busy_at_done", i, int'(busy_v[i]), 0);
                  end
                  in_frame[i] = 0;
                  last_done[i] = cyc;
               end
            end
            prev_busy[i]  = busy_v[i];
            prev_srclk[i] = srclk_v[i];
         end
         chk_zero = RST;
      end
   end

   // Stimulus
   task automatic set_vld(input int inst, input logic [7:0] d, input logic v);
      case (inst)
         0: begin din_m = d; vld_m = v; end
         1: begin din_l = d; vld_l = v; end
         default: begin din_s = d[3:0]; vld_s = v; end
      endcase
   endtask

   task automatic expect_frame(input int inst, input logic [7:0] w, input int gap, input bit ab);
      frame_t f;
      f.word = w; f.gap = gap; f.abort = ab;
      exp_q[inst].push_back(f);
   endtask

   task automatic send(input int inst, input logic [7:0] d);
      @(posedge CLK); #1;
      set_vld(inst, d, 1'b1);
      @(posedge CLK); #1;
      set_vld(inst, d, 1'b0);
   endtask

   task automatic drain(input int inst, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge CLK);
         if (exp_q[inst].size() == 0 && !busy_v[inst]) break;
      end
      check("drain_remaining", inst, exp_q[inst].size(), 0);
      repeat (20) @(posedge CLK);
   endtask

   initial begin
      bit got_done;
      RST = 1'b1;
      din_m = '0; din_l = '0; din_s = '0;
      vld_m = 1'b0; vld_l = 1'b0; vld_s = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (2) @(posedge CLK);

      // Single frame, MSB first: bits 1,0,1,0,0,1,0,1
      expect_frame(0, 8'hA5, -1, 1'b0);
      send(0, 8'hA5);
      drain(0, 200);

      // Two updates during a frame: only the latest follows, one idle cycle after DONE
      expect_frame(0, 8'h01, -1, 1'b0);
      send(0, 8'h01);
      repeat (10) @(posedge CLK);
      send(0, 8'h02);
      repeat (10) @(posedge CLK);
      expect_frame(0, 8'h03, 1, 1'b0);
      send(0, 8'h03);
      drain(0, 300);

      // Strobe landing in the DONE cycle replaces the buffered value
      expect_frame(0, 8'h11, -1, 1'b0);
      send(0, 8'h11);
      repeat (5) @(posedge CLK);
      send(0, 8'h77);
      got_done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (done_m) begin
            got_done = 1'b1;
            break;
         end
      end
      check("done_seen_for_overlap", 0, int'(got_done), 1);
      expect_frame(0, 8'h3C, 1, 1'b0);
      set_vld(0, 8'h3C, 1'b1);
      @(posedge CLK); #1;
      set_vld(0, 8'h3C, 1'b0);
      drain(0, 300);

      // Reset mid-frame: RST high during cycle 30, outputs cleared from cycle 31
      expect_frame(0, 8'hFF, -1, 1'b1);
      send(0, 8'hFF);
      repeat (30) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (100) @(posedge CLK);
      check("abort_consumed", 0, exp_q[0].size(), 0);

      // LSB first: 8'h80 arrives as 0,0,0,0,0,0,0,1
      expect_frame(1, 8'h01, -1, 1'b0);
      send(1, 8'h80);
      drain(1, 200);

      // WIDTH=4, CLK_DIV=1: bits 1,0,0,1, DONE 9 cycles after start
      expect_frame(2, 8'h09, -1, 1'b0);
      send(2, 8'h09);
      drain(2, 50);

      for (int i = 0; i < 3; i++) begin
         check("done_total", i, done_tot[i], NDONE[i]);
         check("queue_empty", i, exp_q[i].size(), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
